// File: rtl/sprite_slot_scheduler.sv
// sprite_slot_scheduler
//   Shares one SPR_SIZE x SPR_SIZE, 2-bit sprite ROM among N_SLOTS on-screen
//   object instances. For each pixel it picks the lowest-index slot that covers
//   (horz,vert), drives the ROM's local coordinates, registers the returned code,
//   and accumulates per-slot player-overlap flags over each frame.
// Ports:
//   clk, rst_n               pixel clock, async active-low reset
//   horz, vert               current pixel coordinates
//   frame_start              1-cycle pulse at start of vertical blank
//   cfg_valid/ready/slot/x/y/en   slot write channel (written to the shadow table)
//   rom_horz, rom_vert       local ROM coordinates (combinational)
//   rom_pix                  ROM pixel code (combinational return)
//   pix_code/pix_hit/pix_slot  registered pixel result, latency 1
//   player_opaque            player sprite opaque, aligned with pix_*
//   coll_flags               per-slot overlap flags of the previous frame

// Per-slot coverage test. Coordinates are widened by one bit so x+SPR_SIZE
// cannot wrap; sprites hanging past the screen edge just clip.
module sprite_slot_hit #(
  parameter int SPR_SIZE = 32,
  parameter int COORD_W  = 10
) (
  input  logic               en_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] horz_i,
  input  logic [COORD_W-1:0] vert_i,
  output logic               hit_o
);
  logic [COORD_W:0] h, v, x0, y0, x1, y1;
  assign h  = {1'b0, horz_i};
  assign v  = {1'b0, vert_i};
  assign x0 = {1'b0, x_i};
  assign y0 = {1'b0, y_i};
  assign x1 = x0 + (COORD_W+1)'(SPR_SIZE);
  assign y1 = y0 + (COORD_W+1)'(SPR_SIZE);
  assign hit_o = en_i && (h >= x0) && (h < x1) && (v >= y0) && (v < y1);
endmodule

module sprite_slot_scheduler #(
  parameter int N_SLOTS  = 4,
  parameter int SPR_SIZE = 32,
  parameter int COORD_W  = 10,
  localparam int SW      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] horz,
  input  logic [COORD_W-1:0] vert,
  input  logic               frame_start,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [SW-1:0]      cfg_slot,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic               cfg_en,
  output logic [COORD_W-1:0] rom_horz,
  output logic [COORD_W-1:0] rom_vert,
  input  logic [1:0]         rom_pix,
  output logic [1:0]         pix_code,
  output logic               pix_hit,
  output logic [SW-1:0]      pix_slot,
  input  logic               player_opaque,
  output logic [N_SLOTS-1:0] coll_flags
);
  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } slot_t;

  slot_t [N_SLOTS-1:0] shadow_q, shadow_d, active_q, active_d;
  logic                pending_q, pending_d;
  logic                rdy_q;
  logic [1:0]          code_q, code_d;
  logic                hit_q, hit_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [N_SLOTS-1:0]  acc_q, acc_d, coll_q, coll_d;

  logic                cfg_fire, cfg_in_range;
  logic [N_SLOTS-1:0]  hit;
  logic                any_hit;
  logic [SW-1:0]       win;
  logic [1:0]          rom_clean;

  // No writes are taken while the table may be committing.
  assign cfg_ready    = rdy_q && !frame_start;
  assign cfg_fire     = cfg_valid && cfg_ready;
  assign cfg_in_range = {1'b0, cfg_slot} < (SW+1)'(N_SLOTS);

  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    active_d  = active_q;
    if (frame_start && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    // Out-of-range slot writes are acknowledged but dropped.
    if (cfg_fire && cfg_in_range) begin
      shadow_d[cfg_slot] = '{en: cfg_en, x: cfg_x, y: cfg_y};
      pending_d          = 1'b1;
    end
  end

  // Stage 0 always looks at the active table as it stands this cycle, so a
  // commit in a frame_start cycle only affects the following pixels.
  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    sprite_slot_hit #(.SPR_SIZE(SPR_SIZE), .COORD_W(COORD_W)) u_hit (
      .en_i   (active_q[g].en),
      .x_i    (active_q[g].x),
      .y_i    (active_q[g].y),
      .horz_i (horz),
      .vert_i (vert),
      .hit_o  (hit[g])
    );
  end

  // Lowest index wins; scanning downward lets the last assignment be the winner.
  always_comb begin
    any_hit = 1'b0;
    win     = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        win     = SW'(i);
      end
    end
  end

  assign rom_horz = any_hit ? (horz - active_q[win].x) : '0;
  assign rom_vert = any_hit ? (vert - active_q[win].y) : '0;

  // Undriven/unknown ROM data falls into the default and reads as transparent.
  always_comb begin
    case (rom_pix)
      2'b01, 2'b10, 2'b11: rom_clean = rom_pix;
      default:             rom_clean = 2'b00;
    endcase
  end

  always_comb begin
    code_d = any_hit ? rom_clean : 2'b00;
    hit_d  = any_hit && (rom_clean != 2'b00);
    slot_d = win;
  end

  // Overlap is judged on the registered pixel; the frame_start cycle's own
  // overlap still lands in the flags published for the finished frame.
  always_comb begin
    acc_d  = acc_q;
    coll_d = coll_q;
    if (hit_q && player_opaque) acc_d[slot_q] = 1'b1;
    if (frame_start) begin
      coll_d = acc_d;
      acc_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      rdy_q     <= 1'b0;
      code_q    <= 2'b00;
      hit_q     <= 1'b0;
      slot_q    <= '0;
      acc_q     <= '0;
      coll_q    <= '0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      rdy_q     <= 1'b1;
      code_q    <= code_d;
      hit_q     <= hit_d;
      slot_q    <= slot_d;
      acc_q     <= acc_d;
      coll_q    <= coll_d;
    end
  end

  assign pix_code   = code_q;
  assign pix_hit    = hit_q;
  assign pix_slot   = slot_q;
  assign coll_flags = coll_q;
endmodule

// File: tb/tb_sprite_slot_scheduler.sv
module tb_sprite_slot_scheduler;
  localparam int N = 4, SPR = 32, CW = 10;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [CW-1:0] horz = '0, vert = '0, cfg_x = '0, cfg_y = '0;
  logic [CW-1:0] rom_horz, rom_vert;
  logic          frame_start = 1'b0, cfg_valid = 1'b0, cfg_en = 1'b0, player_opaque = 1'b0;
  logic          cfg_ready, pix_hit;
  logic [1:0]    cfg_slot = '0, pix_slot, rom_pix, pix_code;
  logic [N-1:0]  coll_flags;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  // Sprite art stand-in: code = (col + row) mod 4.
  function automatic logic [1:0] rom_f(int c, int r);
    return 2'((c + r) % 4);
  endfunction
  assign rom_pix = rom_f(int'(rom_horz), int'(rom_vert));

  sprite_slot_scheduler #(.N_SLOTS(N), .SPR_SIZE(SPR), .COORD_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .horz(horz), .vert(vert), .frame_start(frame_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_slot(cfg_slot),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en),
    .rom_horz(rom_horz), .rom_vert(rom_vert), .rom_pix(rom_pix),
    .pix_code(pix_code), .pix_hit(pix_hit), .pix_slot(pix_slot),
    .player_opaque(player_opaque), .coll_flags(coll_flags)
  );

  // Behavioural model: tables as plain arrays, outputs from the coverage rules.
  int       a_x[N], a_y[N], s_x[N], s_y[N];
  bit       a_en[N], s_en[N];
  bit       pend, rdy, e_hit;
  bit [N-1:0] acc, coll;
  int       e_code, e_slot;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      a_x[i] = 0; a_y[i] = 0; a_en[i] = 0; s_x[i] = 0; s_y[i] = 0; s_en[i] = 0;
    end
    pend = 0; rdy = 0; e_hit = 0; acc = '0; coll = '0; e_code = 0; e_slot = 0;
  endtask

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One pixel cycle: drive, check comb outputs, clock, update model, check regs.
  task automatic step(int h, int v, bit fs, bit opq);
    int win, eh, ev;
    bit take;
    bit [N-1:0] a;
    @(negedge clk);
    horz = CW'(h); vert = CW'(v); frame_start = fs; player_opaque = opq;
    #1;
    win = -1;
    for (int i = N - 1; i >= 0; i--)
      if (a_en[i] && h >= a_x[i] && h < a_x[i] + SPR && v >= a_y[i] && v < a_y[i] + SPR)
        win = i;
    eh = (win >= 0) ? h - a_x[win] : 0;
    ev = (win >= 0) ? v - a_y[win] : 0;
    chk("rom_horz", int'(rom_horz), eh);
    chk("rom_vert", int'(rom_vert), ev);
    chk("cfg_ready", int'(cfg_ready), int'(rdy && !fs));
    take = cfg_valid && rdy && !fs;
    @(posedge clk);
    a = acc;
    if (e_hit && opq) a[e_slot] = 1'b1;
    if (fs) begin coll = a; acc = '0; end else acc = a;
    if (fs && pend) begin
      for (int i = 0; i < N; i++) begin a_x[i] = s_x[i]; a_y[i] = s_y[i]; a_en[i] = s_en[i]; end
      pend = 0;
    end
    e_code = (win >= 0) ? int'(rom_f(eh, ev)) : 0;
    e_hit  = (e_code != 0);
    e_slot = (win >= 0) ? win : 0;
    if (take) begin
      s_x[cfg_slot] = int'(cfg_x); s_y[cfg_slot] = int'(cfg_y); s_en[cfg_slot] = cfg_en;
      pend = 1;
    end
    rdy = 1;
    #1;
    chk("pix_code", int'(pix_code), e_code);
    chk("pix_hit", int'(pix_hit), int'(e_hit));
    chk("pix_slot", int'(pix_slot), e_slot);
    chk("coll_flags", int'(coll_flags), int'(coll));
  endtask

  task automatic cfg(int slot, int x, int y, bit en);
    cfg_valid = 1; cfg_slot = 2'(slot); cfg_x = CW'(x); cfg_y = CW'(y); cfg_en = en;
    step(0, 0, 0, 0);
    cfg_valid = 0;
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cfg_ready", int'(cfg_ready), 0);
    chk("rst_pix_code", int'(pix_code), 0);
    chk("rst_pix_hit", int'(pix_hit), 0);
    chk("rst_pix_slot", int'(pix_slot), 0);
    chk("rst_coll", int'(coll_flags), 0);
    @(negedge clk); rst_n = 1;

    // T1: empty tables, sweep part of a frame
    step(0, 0, 1, 0);
    for (int v = 0; v < 480; v += 97)
      for (int h = 0; h < 640; h += 53) step(h, v, 0, 0);
    chk("t1_rom_h", int'(rom_horz), 0);
    chk("t1_coll", int'(coll_flags), 0);

    // T2: slot0 at (100,50)
    cfg(0, 100, 50, 1);
    step(0, 0, 1, 0);
    step(115, 60, 0, 0);
    chk("t2_rom_h", int'(rom_horz), 15);
    chk("t2_rom_v", int'(rom_vert), 10);
    chk("t2_code", int'(pix_code), 1);
    chk("t2_hit", int'(pix_hit), 1);

    // T3: priority, transparent winner does not fall through
    cfg(0, 0, 0, 0);
    cfg(1, 100, 50, 1);
    cfg(2, 110, 50, 1);
    step(0, 0, 1, 0);
    step(120, 54, 0, 0);
    chk("t3_slot", int'(pix_slot), 1);
    chk("t3_hit", int'(pix_hit), 0);
    chk("t3_code", int'(pix_code), 0);
    step(135, 54, 0, 0);
    chk("t3_slot2", int'(pix_slot), 2);

    // T4: mid-frame move takes effect only after frame_start
    cfg(0, 100, 50, 1);
    step(0, 0, 1, 0);
    cfg(0, 200, 50, 1);
    step(115, 60, 0, 0);
    chk("t4_old_slot", int'(pix_slot), 0);
    chk("t4_old_rom", int'(rom_horz), 15);
    step(215, 60, 0, 0);
    chk("t4_not_yet", int'(pix_hit), 0);
    step(0, 0, 1, 0);
    step(215, 60, 0, 0);
    chk("t4_new_rom", int'(rom_horz), 15);
    chk("t4_new_slot", int'(pix_slot), 0);

    // T5: cfg_valid held across frame_start
    cfg_valid = 1; cfg_slot = 2'd3; cfg_x = CW'(300); cfg_y = CW'(300); cfg_en = 1;
    step(0, 0, 1, 0);
    chk("t5_ready_fs", int'(cfg_ready), 0);
    step(0, 0, 0, 0);
    cfg_valid = 0;
    step(310, 310, 0, 0);
    chk("t5_not_commit", int'(pix_slot), 0);
    step(0, 0, 1, 0);
    step(310, 310, 0, 0);
    chk("t5_slot", int'(pix_slot), 3);
    chk("t5_rom_v", int'(rom_vert), 10);

    // T6: clipping at screen corner plus collision flag
    cfg(3, 630, 470, 1);
    step(0, 0, 1, 0);
    step(639, 479, 0, 0);
    chk("t6_rom_h", int'(rom_horz), 9);
    chk("t6_rom_v", int'(rom_vert), 9);
    chk("t6_hit", int'(pix_hit), 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("t6_coll", int'(coll_flags), 8);
    step(5, 5, 0, 0);
    chk("t6_coll_hold", int'(coll_flags), 8);
    step(0, 0, 1, 0);
    chk("t6_coll_clr", int'(coll_flags), 0);

    // Reset mid-frame with a pending write
    cfg(1, 400, 400, 1);
    @(negedge clk); rst_n = 0;
    #1;
    model_reset();
    chk("mrst_ready", int'(cfg_ready), 0);
    chk("mrst_code", int'(pix_code), 0);
    chk("mrst_slot", int'(pix_slot), 0);
    @(negedge clk); rst_n = 1;
    step(0, 0, 1, 0);
    step(410, 410, 0, 0);
    chk("mrst_no_commit", int'(rom_horz), 0);
    step(215, 60, 0, 0);
    chk("mrst_cleared", int'(rom_horz), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
